// File: rtl/timer_entry_pkg.sv
// Shared widths, state encoding and keypad helpers for the MM:SS digit entry block.
package timer_entry_pkg;

    localparam int BCD_W            = 4;
    localparam int NUM_DIGITS       = 4;
    localparam int DEF_MAX_SEC_TENS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2
    } entry_state_e;

    function automatic logic is_one_hot(input logic [9:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return seen & ~multi;
    endfunction

    function automatic logic [BCD_W-1:0] key_to_bcd(input logic [9:0] v);
        logic [BCD_W-1:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) d = BCD_W'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/timer_digit_entry_debouncer.sv
// Keypad debounce: a one-hot pattern stable for DEBOUNCE_CYCLES samples is accepted once,
// then the keypad must read idle for DEBOUNCE_CYCLES samples before the next accept.
module key_debouncer
    import timer_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [9:0]       keypad,
    output logic             digit_valid,
    output logic [BCD_W-1:0] digit
);

    localparam logic [7:0] CNT_LOAD = 8'(DEBOUNCE_CYCLES);

    logic [9:0] prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_next;
    logic       armed_q;
    logic       stable;

    // cnt holds the samples still missing; zero means the pattern is settled
    always_comb begin
        cnt_next = 8'd0;
        if (keypad != prev_q)
            cnt_next = CNT_LOAD - 8'd1;
        else if (cnt_q != 8'd0)
            cnt_next = cnt_q - 8'd1;
    end

    assign stable      = (cnt_next == 8'd0);
    assign digit_valid = stable & armed_q & is_one_hot(keypad);
    assign digit       = key_to_bcd(keypad);

    always_ff @(posedge clk) begin
        if (clear) begin
            prev_q  <= '0;
            cnt_q   <= CNT_LOAD;
            armed_q <= 1'b1;
        end else begin
            prev_q <= keypad;
            cnt_q  <= cnt_next;
            if (digit_valid)
                armed_q <= 1'b0;
            else if (stable && keypad == 10'd0)
                armed_q <= 1'b1;
        end
    end

endmodule

// File: rtl/timer_digit_entry.sv
// Digit entry front-end for the MM:SS counter chain: shift buffer, START/CANCEL handling
// and the one-cycle active-low load strobe.
//   state    | meaning
//   ST_IDLE  | buffer empty, waiting for a digit
//   ST_ENTRY | 1..4 digits buffered
//   ST_LOAD  | load strobe low, digits held for the counters
module timer_digit_entry
    import timer_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_SEC_TENS    = DEF_MAX_SEC_TENS
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [9:0]       keypad,
    input  logic             key_start,
    input  logic             key_cancel,
    input  logic             timer_running,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_units,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_units,
    output logic             load,
    output logic             entry_active,
    output logic             invalid
);

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = BCD_W'(MAX_SEC_TENS);
    localparam logic [2:0]       COUNT_FULL   = 3'(NUM_DIGITS);

    entry_state_e                          state_q, state_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]      buf_q, buf_d;
    logic [2:0]                            count_q, count_d;
    logic                                  load_q, load_d;
    logic                                  invalid_q, invalid_d;
    logic                                  active_q;
    logic                                  start_q, cancel_q;
    logic                                  start_edge, cancel_edge;
    logic                                  digit_valid;
    logic [BCD_W-1:0]                      digit;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .clear      (clear),
        .keypad     (keypad),
        .digit_valid(digit_valid),
        .digit      (digit)
    );

    assign start_edge  = key_start & ~start_q;
    assign cancel_edge = key_cancel & ~cancel_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        load_d    = 1'b1;
        invalid_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                state_d = ST_IDLE;
                buf_d   = '0;
                count_d = 3'd0;
            end
            default: begin
                // order below is the in-cycle priority: CANCEL, START, digit
                if (!timer_running) begin
                    if (cancel_edge) begin
                        state_d = ST_IDLE;
                        buf_d   = '0;
                        count_d = 3'd0;
                    end else if (start_edge) begin
                        if (count_q == 3'd0 || buf_q[1] > SEC_TENS_MAX) begin
                            invalid_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            load_d  = 1'b0;
                        end
                    end else if (digit_valid && count_q != COUNT_FULL) begin
                        state_d = ST_ENTRY;
                        buf_d   = {buf_q[NUM_DIGITS-2:0], digit};
                        count_d = count_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            count_q   <= 3'd0;
            load_q    <= 1'b1;
            invalid_q <= 1'b0;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            load_q    <= load_d;
            invalid_q <= invalid_d;
            active_q  <= (count_d != 3'd0);
            start_q   <= key_start;
            cancel_q  <= key_cancel;
        end
    end

    assign min_tens     = buf_q[3];
    assign min_units    = buf_q[2];
    assign sec_tens     = buf_q[1];
    assign sec_units    = buf_q[0];
    assign load         = load_q;
    assign entry_active = active_q;
    assign invalid      = invalid_q;

endmodule
